// File: rtl/psum_row_accumulator.sv
// Accumulates the PE grid's top-row psum vector over several input-channel passes,
// then drains the finished ofmap row one column per handshake with optional ReLU.
module psum_row_accumulator #(
  parameter int COLS   = 14,
  parameter int PSUM_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           cfg_passes,
  input  logic                       cfg_relu,
  input  logic signed [PSUM_W-1:0]   psum_in_vec [COLS],
  input  logic                       psum_in_valid,
  output logic                       psum_in_ready,
  output logic [PSUM_W-1:0]          out_data,
  output logic [$clog2(COLS)-1:0]    out_col,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int COL_W = $clog2(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          passes_q;
  logic [CNT_W-1:0]          pass_cnt;
  logic                      relu_q;
  logic [COL_W-1:0]          col_q;
  logic                      done_q;
  logic signed [PSUM_W-1:0]  acc [COLS];

  logic pass_take;
  logic last_pass;
  logic beat_take;
  logic last_col;

  function automatic logic [PSUM_W-1:0] relu_clamp(input logic signed [PSUM_W-1:0] v,
                                                   input logic en);
    return (en && v[PSUM_W-1]) ? '0 : v;
  endfunction

  assign pass_take = (state_q == ACCUM) && psum_in_valid;
  assign last_pass = (pass_cnt == passes_q - CNT_W'(1));
  assign beat_take = (state_q == DRAIN) && out_ready;
  assign last_col  = (col_q == LAST_COL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (pass_take && last_pass) state_d = DRAIN;
      DRAIN:   if (beat_take && last_col) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control: state, latched job configuration, pass and column counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      passes_q <= '0;
      relu_q   <= 1'b0;
      pass_cnt <= '0;
      col_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= beat_take && last_col;
      if (state_q == IDLE && start) begin
        passes_q <= (cfg_passes == '0) ? CNT_W'(1) : cfg_passes;
        relu_q   <= cfg_relu;
        pass_cnt <= '0;
      end
      if (pass_take) begin
        pass_cnt <= pass_cnt + CNT_W'(1);
        if (last_pass) col_q <= '0;
      end
      if (beat_take) col_q <= col_q + COL_W'(1);
    end
  end

  // accumulator lanes: pass 0 overwrites so no clear cycle is needed between jobs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < COLS; c++) acc[c] <= '0;
    end else if (pass_take) begin
      for (int c = 0; c < COLS; c++)
        acc[c] <= (pass_cnt == '0) ? psum_in_vec[c] : acc[c] + psum_in_vec[c];
    end
  end

  // drain outputs decode registered state only, never out_ready
  assign psum_in_ready = (state_q == ACCUM);
  assign busy          = (state_q != IDLE);
  assign out_valid     = (state_q == DRAIN);
  assign out_col       = col_q;
  assign out_last      = out_valid && last_col;
  assign out_data      = out_valid ? relu_clamp(acc[col_q], relu_q) : '0;
  assign done          = done_q;

endmodule

// File: tb/tb_psum_row_accumulator.sv
// Directed bench for psum_row_accumulator: a scoreboard queue of expected drain beats
// is filled as passes are driven and drained against the DUT output stream.
module tb_psum_row_accumulator;

  localparam int COLS = 14;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [3:0]          cfg_passes;
  logic                cfg_relu;
  logic signed [31:0]  psum_in_vec [COLS];
  logic                psum_in_valid;
  logic                psum_in_ready;
  logic [31:0]         out_data;
  logic [3:0]          out_col;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic                done;

  psum_row_accumulator #(.COLS(14), .PSUM_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_passes(cfg_passes), .cfg_relu(cfg_relu),
    .psum_in_vec(psum_in_vec), .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
    .out_data(out_data), .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  col;
    logic        last;
  } beat_t;

  int                 vectors = 0;
  int                 miscompares = 0;
  beat_t              sb [$];
  logic signed [31:0] m_acc [COLS];
  logic signed [31:0] vec [COLS];
  int                 m_pass;
  int                 m_passes;
  logic               m_relu;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tasks are entered and left at a falling edge; inputs change only there.
  task automatic start_job(input int passes, input logic relu);
    start = 1'b1; cfg_passes = 4'(passes); cfg_relu = relu;
    m_passes = (passes == 0) ? 1 : passes;
    m_relu = relu;
    m_pass = 0;
    @(negedge clk);
    start = 1'b0; cfg_passes = 4'hF; cfg_relu = ~relu;
    check("start_ready", 32'(psum_in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic feed(input int gaps);
    beat_t b;
    for (int g = 0; g < gaps; g++) begin
      psum_in_valid = 1'b0;
      @(negedge clk);
    end
    check("feed_ready", 32'(psum_in_ready), 32'd1);
    psum_in_valid = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      psum_in_vec[c] = vec[c];
      m_acc[c] = (m_pass == 0) ? vec[c] : m_acc[c] + vec[c];
    end
    m_pass++;
    if (m_pass == m_passes) begin
      for (int c = 0; c < COLS; c++) begin
        b.data = (m_relu && m_acc[c] < 0) ? 32'd0 : m_acc[c];
        b.col  = 4'(c);
        b.last = (c == COLS - 1);
        sb.push_back(b);
      end
    end
    @(negedge clk);
    if (m_pass == m_passes) begin
      check("drain_latency_valid", 32'(out_valid), 32'd1);
      check("drain_latency_col", 32'(out_col), 32'd0);
    end else begin
      check("accum_no_out", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic drain(input bit rand_ready, input bit noise);
    int budget = 400;
    psum_in_valid = 1'b0;
    while (sb.size() > 0 && budget > 0) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        start = 1'b1; cfg_relu = ~m_relu; cfg_passes = 4'd1;
      end
      check("beat_valid", 32'(out_valid), 32'd1);
      check("beat_data", out_data, sb[0].data);
      check("beat_col", 32'(out_col), 32'(sb[0].col));
      check("beat_last", 32'(out_last), 32'(sb[0].last));
      check("beat_in_ready", 32'(psum_in_ready), 32'd0);
      if (out_ready) void'(sb.pop_front());
      @(negedge clk);
      budget--;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_out_valid", 32'(out_valid), 32'd0);
    check("done_in_ready", 32'(psum_in_ready), 32'd0);
  endtask

  task automatic idle_after_done();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; cfg_passes = 4'd0; cfg_relu = 1'b0;
    psum_in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      psum_in_vec[c] = '0;
      vec[c] = '0;
      m_acc[c] = '0;
    end
    #3;
    check("rst_in_ready", 32'(psum_in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(psum_in_ready), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);

    // single pass, ramp -50..80
    for (int c = 0; c < COLS; c++) vec[c] = c * 10 - 50;
    start_job(1, 1'b0);
    feed(0);
    drain(1'b0, 1'b0);
    idle_after_done();

    // three back-to-back passes, ReLU on, stray start/config during the job
    start_job(3, 1'b1);
    for (int c = 0; c < COLS; c++) vec[c] = 5;
    feed(0);
    for (int c = 0; c < COLS; c++) vec[c] = 7;
    start = 1'b1; cfg_passes = 4'd1; cfg_relu = 1'b0;
    feed(0);
    start = 1'b0;
    for (int c = 0; c < COLS; c++) vec[c] = -20;
    feed(0);
    drain(1'b0, 1'b1);
    idle_after_done();

    // same sums without ReLU, random backpressure
    start_job(3, 1'b0);
    for (int c = 0; c < COLS; c++) vec[c] = 5;
    feed(0);
    for (int c = 0; c < COLS; c++) vec[c] = 7;
    feed(0);
    for (int c = 0; c < COLS; c++) vec[c] = -20;
    feed(0);
    drain(1'b1, 1'b0);
    idle_after_done();

    // zero passes acts as one; restart during the done cycle
    for (int c = 0; c < COLS; c++) vec[c] = $urandom;
    start_job(0, 1'b0);
    feed(0);
    drain(1'b0, 1'b0);
    start_job(2, 1'b0);
    vec[0] = 32'sh7FFFFFFF;
    for (int c = 1; c < COLS; c++) vec[c] = $urandom;
    feed(2);
    for (int c = 1; c < COLS; c++) vec[c] = $urandom;
    feed(3);
    drain(1'b1, 1'b0);
    idle_after_done();

    // valid vectors in IDLE must not be taken
    for (int c = 0; c < COLS; c++) psum_in_vec[c] = 32'sh12345678;
    psum_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ignores_ready", 32'(psum_in_ready), 32'd0);
      check("idle_ignores_valid", 32'(out_valid), 32'd0);
    end
    psum_in_valid = 1'b0;
    for (int c = 0; c < COLS; c++) vec[c] = (c % 2 == 0) ? -(c + 1) : c * 1000;
    start_job(1, 1'b1);
    feed(0);
    drain(1'b1, 1'b0);
    idle_after_done();

    // asynchronous reset in the middle of a drain
    for (int c = 0; c < COLS; c++) vec[c] = c + 100;
    start_job(1, 1'b0);
    feed(0);
    psum_in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_drain_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_out_col", 32'(out_col), 32'd0);
    check("arst_out_last", 32'(out_last), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(psum_in_ready), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    sb.delete();
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_arst_done", 32'(done), 32'd0);
      check("post_arst_ready", 32'(psum_in_ready), 32'd0);
      check("post_arst_busy", 32'(busy), 32'd0);
    end

    // block still works after the abort
    for (int c = 0; c < COLS; c++) vec[c] = $urandom;
    start_job(1, 1'b0);
    feed(0);
    drain(1'b0, 1'b0);
    idle_after_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
